samp_ram_arb: RTL and testbench
===============================

Name: samp_ram_arb

Overview:
- Arbitrates the single port of the sample RAM between two requesters: the command parser (host read/write) and the sample generator (playback reads).
- Sample generator has priority, bounded by a starvation guard so host commands (*W/*R-style accesses) always complete.
- Read data returns to the requester that issued the read, tagged through a latency-matched pipeline.

Parameters:
ADDR_W, 10, sample RAM address width
DATA_W, 16, sample word width
RAM_LAT, 1, RAM read latency in cycles from ram_en to ram_dout valid; legal 1..3
STARVE_MAX, 4, consecutive generator wins while cmd_req pending before cmd is forced; legal 1..15

Ports:
clk_rx  in  1  receive-domain clock; all logic on rising edge
rst_clk_rx_n  in  1  reset, asynchronous assert, active-low
cmd_req  in  1  command-side access request; held with fields stable until cmd_ack
cmd_we  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  command address
cmd_wdata  in  DATA_W  command write data
cmd_ack  out  1  combinational grant pulse; request consumed this cycle
cmd_rvalid  out  1  registered one-cycle read-data strobe
cmd_rdata  out  DATA_W  read data, valid with cmd_rvalid
gen_req  in  1  generator read request; same hold rule
gen_addr  in  ADDR_W  generator read address
gen_ack  out  1  combinational grant pulse
gen_rvalid  out  1  registered read-data strobe
gen_rdata  out  DATA_W  read data
gen_stall  out  1  registered; 1 when gen_req was high and not acked the previous cycle
ram_en  out  1  RAM enable, registered
ram_we  out  1  RAM write enable, registered
ram_addr  out  ADDR_W  registered
ram_din  out  DATA_W  registered
ram_dout  in  DATA_W  RAM read data, valid RAM_LAT cycles after ram_en

Behaviour:
- Reset: all outputs 0; starvation counter 0; tag pipeline cleared. Async assert, sync deassert handled upstream.
- At most one grant per cycle. Grant decision in cycle t is combinational from req inputs and counter:
  - only gen_req: gen_ack=1.
  - only cmd_req: cmd_ack=1.
  - both: gen wins unless starve_cnt==STARVE_MAX, then cmd wins.
  - neither: no ack.
- Requester may assert a new request (new fields) in t+1 after ack; back-to-back grants to one requester every cycle are legal.
- Cycle t+1: ram_en=1, ram_we=granted we (gen always 0), ram_addr/ram_din from the granted requester captured at t. No grant at t: ram_en=0, ram_we=0; addr/din hold.
- Read return: tag shift register (valid, owner) depth RAM_LAT+1. ram_dout is sampled at t+1+RAM_LAT. The owner's rvalid/rdata are registered at t+2+RAM_LAT, so ack-to-rvalid latency is RAM_LAT+2 (3 for default). Writes produce no rvalid. The non-owner's rdata holds its last value.
- Starvation counter:
  - increments, saturating at STARVE_MAX, when gen is granted while cmd_req=1.
  - clears when cmd is granted.
  - holds otherwise.
- gen_stall: registered gen_req & ~gen_ack.
- Read ordering per requester is preserved; rvalid pulses are never merged or dropped.
- Reset mid-operation: in-flight reads are discarded, and no rvalid appears after reset release for pre-reset grants.
- Requester dropping req without ack is legal; nothing is issued.

Test Plan:
- Reset then idle 20 cycles -> all outputs 0, ram_en never asserts.
- cmd write addr 0x001 data 0x5678, then cmd read 0x001 -> ram_we=1 at t+1; read gives cmd_ack, then cmd_rvalid=1 with cmd_rdata=0x5678 exactly 3 cycles later (RAM_LAT=1); gen_rvalid stays 0.
- gen_req held high continuously, addresses 0..7 incrementing -> 8 consecutive gen_ack, gen_rvalid pulses in 8 consecutive cycles, data in address order, gen_stall=0 throughout.
- gen_req continuous and cmd read of 0x003 (preloaded 0xdef0) pending, STARVE_MAX=4 -> 4 gen grants, cmd_ack on the 5th cycle, one gen_stall=1 the following cycle, cmd_rdata=0xdef0.
- Both reqs asserted the same cycle with counter 0 -> gen_ack=1, cmd_ack=0; counter reaches 1.
- Assert rst_clk_rx_n=0 one cycle after a gen read ack, release after 2 cycles -> no gen_rvalid for that read; all outputs 0 during reset; next request serviced normally.

Source files
------------

// File: rtl/samp_ram_arb.sv
`default_nettype none
// ============================================================================
//  Module      : samp_ram_arb
//  Description : Single-port sample RAM arbiter between the command parser
//                (host read/write) and the sample generator (playback reads).
//                The generator has priority. A starvation counter guarantees
//                that a pending command is eventually granted. Read data is
//                routed back to the requester that issued the read, using a
//                tag pipeline whose depth matches the RAM latency.
//  Ports       : clk_rx / rst_clk_rx_n     - clock, async active-low reset
//                cmd_*                     - command requester (rd/wr)
//                gen_*                     - generator requester (rd only)
//                ram_*                     - registered RAM port, ram_dout in
//  Revision    : 1.0 - initial release
// ============================================================================
module samp_ram_arb #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 16,
   parameter int RAM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk_rx,
   input  logic              rst_clk_rx_n,
   input  logic              cmd_req,
   input  logic              cmd_we,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              cmd_ack,
   output logic              cmd_rvalid,
   output logic [DATA_W-1:0] cmd_rdata,
   input  logic              gen_req,
   input  logic [ADDR_W-1:0] gen_addr,
   output logic              gen_ack,
   output logic              gen_rvalid,
   output logic [DATA_W-1:0] gen_rdata,
   output logic              gen_stall,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   localparam int              CNT_W        = 4;
   localparam int              TAG_D        = RAM_LAT + 1;
   localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic [TAG_D-1:0]  tag_vld_q,    tag_vld_d;
   logic [TAG_D-1:0]  tag_gen_q,    tag_gen_d;
   logic              ram_en_q,     ram_en_d;
   logic              ram_we_q,     ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q,   ram_addr_d;
   logic [DATA_W-1:0] ram_din_q,    ram_din_d;
   logic              cmd_rvalid_q, cmd_rvalid_d;
   logic [DATA_W-1:0] cmd_rdata_q,  cmd_rdata_d;
   logic              gen_rvalid_q, gen_rvalid_d;
   logic [DATA_W-1:0] gen_rdata_q,  gen_rdata_d;
   logic              gen_stall_q,  gen_stall_d;

   logic              cmd_forced;
   logic              rd_issue;

   // Grant: generator wins unless the command has been passed over
   // STARVE_MAX times in a row while waiting.
   always_comb begin
      cmd_forced = cmd_req && (starve_cnt_q == STARVE_LIMIT);
      gen_ack    = gen_req && !cmd_forced;
      cmd_ack    = cmd_req && !gen_ack;
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (cmd_ack) begin
         starve_cnt_d = '0;
      end else if (gen_ack && cmd_req && (starve_cnt_q != STARVE_LIMIT)) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end

      // RAM port: address/data hold when nothing is granted. A generator
      // grant has no write data, so ram_din keeps its previous value.
      ram_en_d   = cmd_ack || gen_ack;
      ram_we_d   = cmd_ack && cmd_we;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      if (cmd_ack) begin
         ram_addr_d = cmd_addr;
         ram_din_d  = cmd_wdata;
      end else if (gen_ack) begin
         ram_addr_d = gen_addr;
      end

      // Tag stage 0 lines up with ram_en; the top stage lines up with valid
      // ram_dout, which is captured into the owner's output register.
      rd_issue  = gen_ack || (cmd_ack && !cmd_we);
      tag_vld_d = {tag_vld_q[TAG_D-2:0], rd_issue};
      tag_gen_d = {tag_gen_q[TAG_D-2:0], gen_ack};

      cmd_rvalid_d = 1'b0;
      gen_rvalid_d = 1'b0;
      cmd_rdata_d  = cmd_rdata_q;
      gen_rdata_d  = gen_rdata_q;
      if (tag_vld_q[TAG_D-1]) begin
         if (tag_gen_q[TAG_D-1]) begin
            gen_rvalid_d = 1'b1;
            gen_rdata_d  = ram_dout;
         end else begin
            cmd_rvalid_d = 1'b1;
            cmd_rdata_d  = ram_dout;
         end
      end

      gen_stall_d = gen_req && !gen_ack;
   end

   always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
      if (!rst_clk_rx_n) begin
         starve_cnt_q <= '0;
         tag_vld_q    <= '0;
         tag_gen_q    <= '0;
         ram_en_q     <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_din_q    <= '0;
         cmd_rvalid_q <= 1'b0;
         cmd_rdata_q  <= '0;
         gen_rvalid_q <= 1'b0;
         gen_rdata_q  <= '0;
         gen_stall_q  <= 1'b0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         tag_vld_q    <= tag_vld_d;
         tag_gen_q    <= tag_gen_d;
         ram_en_q     <= ram_en_d;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_din_q    <= ram_din_d;
         cmd_rvalid_q <= cmd_rvalid_d;
         cmd_rdata_q  <= cmd_rdata_d;
         gen_rvalid_q <= gen_rvalid_d;
         gen_rdata_q  <= gen_rdata_d;
         gen_stall_q  <= gen_stall_d;
      end
   end

   assign ram_en     = ram_en_q;
   assign ram_we     = ram_we_q;
   assign ram_addr   = ram_addr_q;
   assign ram_din    = ram_din_q;
   assign cmd_rvalid = cmd_rvalid_q;
   assign cmd_rdata  = cmd_rdata_q;
   assign gen_rvalid = gen_rvalid_q;
   assign gen_rdata  = gen_rdata_q;
   assign gen_stall  = gen_stall_q;

endmodule
`default_nettype wire

// File: tb/tb_samp_ram_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_samp_ram_arb
//  Description : Self-checking bench for samp_ram_arb. A behavioural RAM
//                drives ram_dout; a reference model predicts grants and read
//                results, and a monitor pops expected reads on each rvalid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_samp_ram_arb;

   localparam int ADDR_W     = 10;
   localparam int DATA_W     = 16;
   localparam int RAM_LAT    = 1;
   localparam int STARVE_MAX = 4;
   localparam int DEPTH      = 1 << ADDR_W;

   logic              clk_rx = 1'b0;
   logic              rst_clk_rx_n = 1'b0;
   logic              cmd_req = 1'b0, cmd_we = 1'b0;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [DATA_W-1:0] cmd_wdata = '0;
   logic              cmd_ack, cmd_rvalid;
   logic [DATA_W-1:0] cmd_rdata;
   logic              gen_req = 1'b0;
   logic [ADDR_W-1:0] gen_addr = '0;
   logic              gen_ack, gen_rvalid, gen_stall;
   logic [DATA_W-1:0] gen_rdata;
   logic              ram_en, ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic [DATA_W-1:0] ram_dout;

   samp_ram_arb #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(RAM_LAT), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk_rx(clk_rx), .rst_clk_rx_n(rst_clk_rx_n),
      .cmd_req(cmd_req), .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .cmd_ack(cmd_ack), .cmd_rvalid(cmd_rvalid), .cmd_rdata(cmd_rdata),
      .gen_req(gen_req), .gen_addr(gen_addr), .gen_ack(gen_ack),
      .gen_rvalid(gen_rvalid), .gen_rdata(gen_rdata), .gen_stall(gen_stall),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_dout(ram_dout)
   );

   always #5 clk_rx = ~clk_rx;

   int cyc = 0;
   always @(posedge clk_rx) cyc <= cyc + 1;

   function automatic logic [DATA_W-1:0] init_val(input int a);
      return DATA_W'((a * 40503) ^ 16'h5a5a);
   endfunction

   // ---------------- behavioural RAM (latency RAM_LAT) ----------------------
   logic [DATA_W-1:0] ram_mem [0:DEPTH-1];
   logic [DATA_W-1:0] rd_pipe [0:RAM_LAT-1];
   bit                ram_init = 1'b0;
   assign ram_dout = rd_pipe[RAM_LAT-1];

   always @(posedge clk_rx) begin
      if (!ram_init) begin
         for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_val(i);
         ram_init <= 1'b1;
      end else if (ram_en && ram_we) begin
         ram_mem[ram_addr] <= ram_din;
      end
      // Garbage when no read is in progress, so a mistimed capture is visible.
      rd_pipe[0] <= (ram_en && !ram_we) ? ram_mem[ram_addr] : DATA_W'($urandom);
      for (int i = 1; i < RAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end

   // ---------------- reference model and scoreboard ------------------------
   typedef struct {
      logic [DATA_W-1:0] data;
      int                cyc;
   } exp_t;

   exp_t              cmd_q[$];
   exp_t              gen_q[$];
   logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
   int                m_cnt = 0;
   bit                exp_stall = 0, exp_en = 0, exp_we = 0;
   logic [ADDR_W-1:0] exp_addr = '0;
   logic [DATA_W-1:0] exp_din = '0;
   logic [DATA_W-1:0] last_cmd_rdata = '0, last_gen_rdata = '0;
   bit                last_pc = 0, last_pg = 0;
   bit                dut_cmd_ack = 0, dut_gen_ack = 0;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Inputs are set right after a falling edge; tick() checks the DUT just
   // after that, advances the model, and returns at the next falling edge.
   task automatic tick();
      bit pc, pg;
      exp_t e;
      #1;
      if (!rst_clk_rx_n) begin
         check("rst_ctl", {cmd_ack, gen_ack, cmd_rvalid, gen_rvalid, gen_stall, ram_en, ram_we}, 0);
         check("rst_data", {cmd_rdata, gen_rdata, ram_din}, 0);
         check("rst_addr", ram_addr, 0);
         m_cnt = 0; exp_stall = 0; exp_en = 0; exp_we = 0; exp_addr = '0; exp_din = '0;
         cmd_q.delete(); gen_q.delete();
         last_cmd_rdata = '0; last_gen_rdata = '0;
         last_pc = 0; last_pg = 0; dut_cmd_ack = 0; dut_gen_ack = 0;
      end else begin
         pg = gen_req && !(cmd_req && m_cnt == STARVE_MAX);
         pc = cmd_req && !pg;
         check("cmd_ack", cmd_ack, pc);
         check("gen_ack", gen_ack, pg);
         check("gen_stall", gen_stall, exp_stall);
         check("ram_en", ram_en, exp_en);
         check("ram_we", ram_we, exp_we);
         check("ram_addr", ram_addr, exp_addr);
         if (exp_en && exp_we) check("ram_din", ram_din, exp_din);
         dut_cmd_ack = cmd_ack; dut_gen_ack = gen_ack;

         exp_stall = gen_req && !pg;
         if (pc) m_cnt = 0;
         else if (pg && cmd_req && m_cnt < STARVE_MAX) m_cnt++;
         exp_en = pc || pg;
         exp_we = pc && cmd_we;
         if (pc) begin
            exp_addr = cmd_addr; exp_din = cmd_wdata;
            if (cmd_we) ref_mem[cmd_addr] = cmd_wdata;
            else begin
               e.data = ref_mem[cmd_addr]; e.cyc = cyc + RAM_LAT + 2;
               cmd_q.push_back(e);
            end
         end else if (pg) begin
            exp_addr = gen_addr;
            e.data = ref_mem[gen_addr]; e.cyc = cyc + RAM_LAT + 2;
            gen_q.push_back(e);
         end
         last_pc = pc; last_pg = pg;
      end
      @(negedge clk_rx);
   endtask

   // ---------------- monitor ------------------------------------------------
   always @(negedge clk_rx) begin
      exp_t e;
      if (rst_clk_rx_n) begin
         while (cmd_q.size() > 0 && cmd_q[0].cyc < cyc) begin
            e = cmd_q.pop_front();
            check("cmd_rvalid_missing", 0, 1);
         end
         while (gen_q.size() > 0 && gen_q[0].cyc < cyc) begin
            e = gen_q.pop_front();
            check("gen_rvalid_missing", 0, 1);
         end
         if (cmd_rvalid) begin
            if (cmd_q.size() == 0) check("cmd_rvalid_unexpected", 1, 0);
            else begin
               e = cmd_q.pop_front();
               check("cmd_rvalid_cycle", cyc, e.cyc);
               check("cmd_rdata", cmd_rdata, e.data);
               last_cmd_rdata = e.data;
            end
         end else check("cmd_rdata_hold", cmd_rdata, last_cmd_rdata);
         if (gen_rvalid) begin
            if (gen_q.size() == 0) check("gen_rvalid_unexpected", 1, 0);
            else begin
               e = gen_q.pop_front();
               check("gen_rvalid_cycle", cyc, e.cyc);
               check("gen_rdata", gen_rdata, e.data);
               last_gen_rdata = e.data;
            end
         end else check("gen_rdata_hold", gen_rdata, last_gen_rdata);
      end
   end

   // ---------------- stimulus helpers --------------------------------------
   task automatic idle(input int n);
      cmd_req = 0; gen_req = 0;
      repeat (n) tick();
   endtask

   task automatic cmd_op(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      int k = 0;
      cmd_req = 1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
      do begin tick(); k++; end while (!last_pc && k < 50);
      check("cmd_op_grant", last_pc, 1);
      cmd_req = 0;
   endtask

   // ---------------- main sequence -----------------------------------------
   initial begin
      int ng, k;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);

      // reset, then idle
      repeat (3) @(negedge clk_rx);
      idle(2);
      rst_clk_rx_n = 1;
      idle(20);

      // command write then read back
      cmd_op(1'b1, ADDR_W'(1), 16'h5678);
      cmd_op(1'b0, ADDR_W'(1), '0);
      idle(5);

      // continuous generator burst
      for (int i = 0; i < 8; i++) begin
         gen_req = 1; gen_addr = ADDR_W'(i);
         tick();
      end
      idle(5);

      // starvation guard: gen continuous, cmd read of 0x003 pending
      cmd_op(1'b1, ADDR_W'(3), 16'hdef0);
      idle(4);
      cmd_req = 1; cmd_we = 0; cmd_addr = ADDR_W'(3);
      ng = 0; k = 0; dut_cmd_ack = 0;
      while (!dut_cmd_ack && k < 20) begin
         gen_req = 1; gen_addr = ADDR_W'(16 + ng);
         tick();
         if (dut_gen_ack) ng++;
         k++;
      end
      check("starve_gen_wins", ng, STARVE_MAX);
      check("starve_cmd_granted", dut_cmd_ack, 1);
      cmd_req = 0;
      gen_addr = ADDR_W'(16 + ng);
      tick();
      idle(6);

      // reset one cycle after a generator grant: that read must vanish
      gen_req = 1; gen_addr = ADDR_W'(5);
      tick();
      gen_req = 0;
      tick();
      rst_clk_rx_n = 0;
      tick(); tick();
      rst_clk_rx_n = 1;
      idle(5);
      gen_req = 1; gen_addr = ADDR_W'(6);
      tick();
      idle(6);

      // randomized traffic with hold rule and occasional withdrawal
      for (int i = 0; i < 1500; i++) begin
         if (!cmd_req || last_pc) begin
            cmd_req   = ($urandom_range(0, 99) < 40);
            cmd_we    = 1'($urandom);
            cmd_addr  = ADDR_W'($urandom_range(0, 31));
            cmd_wdata = DATA_W'($urandom);
         end else if ($urandom_range(0, 99) < 3) cmd_req = 0;
         if (!gen_req || last_pg) begin
            gen_req  = ($urandom_range(0, 99) < 70);
            gen_addr = ADDR_W'($urandom_range(0, 31));
         end else if ($urandom_range(0, 99) < 3) gen_req = 0;
         tick();
      end
      idle(10);
      check("cmd_q_drained", cmd_q.size(), 0);
      check("gen_q_drained", gen_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
